// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch stage with a one-deep instruction register.
//
// The block keeps a fetch address (Fetch_PC), issues read requests to
// instruction memory, and captures each returned word together with its
// address into a registered output slot (Instr/PC/PC_plus_one). Decode takes
// the slot by leaving Stall low while Instr_valid is high. A Jump or
// Branch_taken redirects fetch to a new address. A redirect discards the slot
// and any word arriving on the same edge. It then spends one bubble cycle in
// REDIRECT before fetching again.
//
// Parameters
//   N         datapath/address width
//   RESET_PC  fetch address loaded on reset
// Ports
//   clk, rst                 clock, async active-high reset
//   Stall                    decode cannot accept the held instruction
//   Branch_taken, ALU_1_out  branch redirect and its target
//   Jump, Jump_target        jump redirect and its target (wins over branch)
//   Imem_req, Imem_addr      read request and address to instruction memory
//   Imem_ack, Imem_data      memory returns a word this cycle
//   Instr, Instr_valid       fetched instruction and its valid flag
//   PC, PC_plus_one          address of Instr and that address + 1
module pc_fetch #(
  parameter int          N        = 16,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Stall,
  input  logic         Branch_taken,
  input  logic [N-1:0] ALU_1_out,
  input  logic         Jump,
  input  logic [N-1:0] Jump_target,
  output logic         Imem_req,
  output logic [N-1:0] Imem_addr,
  input  logic         Imem_ack,
  input  logic [N-1:0] Imem_data,
  output logic [N-1:0] Instr,
  output logic         Instr_valid,
  output logic [N-1:0] PC,
  output logic [N-1:0] PC_plus_one
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] Fetch_PC;
  logic [N-1:0] fetch_pc_inc;
  logic [N-1:0] redirect_target;
  logic         redirect;
  logic         transfer;
  logic         consume;

  // The request is withheld only while a valid instruction is stuck behind a
  // stall. The slot cannot take a new word then.
  assign Imem_req  = (state == FETCH) && !(Instr_valid && Stall);
  assign Imem_addr = Fetch_PC;

  assign fetch_pc_inc    = Fetch_PC + N'(1);
  assign redirect        = Jump || Branch_taken;
  assign redirect_target = Jump ? Jump_target : ALU_1_out;
  assign transfer        = Imem_req && Imem_ack && !redirect;
  assign consume         = Instr_valid && !Stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      Fetch_PC    <= RESET_PC;
      Instr       <= '0;
      PC          <= '0;
      PC_plus_one <= '0;
      Instr_valid <= 1'b0;
    end else if (redirect) begin
      // Redirect wins over stall and over a word returning on this edge.
      // Repeated redirects keep loading the newest target.
      state       <= REDIRECT;
      Fetch_PC    <= redirect_target;
      Instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE:     state <= FETCH;
        REDIRECT: state <= FETCH;
        FETCH:    state <= FETCH;
        default:  state <= IDLE;
      endcase

      if (transfer) begin
        Instr       <= Imem_data;
        PC          <= Fetch_PC;
        PC_plus_one <= fetch_pc_inc;
        Instr_valid <= 1'b1;
        Fetch_PC    <= fetch_pc_inc;
      end else if (consume) begin
        Instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch. A combinational memory model returns
// addr ^ 0xA5A5 for every address. Inputs change 1 time unit after each rising
// edge. Outputs are checked at that same point.
module tb_pc_fetch;

  localparam int N = 16;

  logic         clk;
  logic         rst;
  logic         Stall;
  logic         Branch_taken;
  logic [N-1:0] ALU_1_out;
  logic         Jump;
  logic [N-1:0] Jump_target;
  logic         Imem_req;
  logic [N-1:0] Imem_addr;
  logic         Imem_ack;
  logic [N-1:0] Imem_data;
  logic [N-1:0] Instr;
  logic         Instr_valid;
  logic [N-1:0] PC;
  logic [N-1:0] PC_plus_one;

  int testsRun;
  int testsFailed;

  pc_fetch #(.N(N), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .Stall       (Stall),
    .Branch_taken(Branch_taken),
    .ALU_1_out   (ALU_1_out),
    .Jump        (Jump),
    .Jump_target (Jump_target),
    .Imem_req    (Imem_req),
    .Imem_addr   (Imem_addr),
    .Imem_ack    (Imem_ack),
    .Imem_data   (Imem_data),
    .Instr       (Instr),
    .Instr_valid (Instr_valid),
    .PC          (PC),
    .PC_plus_one (PC_plus_one)
  );

  assign Imem_data = Imem_addr ^ 16'hA5A5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Check the delivered slot against a hand-computed address.
  task automatic checkSlot(input string tag, input logic [N-1:0] addr);
    logic [N-1:0] exp_instr;
    logic [N-1:0] exp_ppo;
    exp_instr = addr ^ 16'hA5A5;
    exp_ppo   = addr + 16'd1;
    checkOutput({tag, "_valid"}, 32'(Instr_valid), 32'd1);
    checkOutput({tag, "_pc"},    32'(PC),          32'(addr));
    checkOutput({tag, "_ppo"},   32'(PC_plus_one), 32'(exp_ppo));
    checkOutput({tag, "_instr"}, 32'(Instr),       32'(exp_instr));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req"},   32'(Imem_req),    32'd0);
    checkOutput({tag, "_addr"},  32'(Imem_addr),   32'h0000);
    checkOutput({tag, "_valid"}, 32'(Instr_valid), 32'd0);
    checkOutput({tag, "_instr"}, 32'(Instr),       32'd0);
    checkOutput({tag, "_pc"},    32'(PC),          32'd0);
    checkOutput({tag, "_ppo"},   32'(PC_plus_one), 32'd0);
  endtask

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    rst          = 1'b1;
    Stall        = 1'b0;
    Branch_taken = 1'b0;
    ALU_1_out    = '0;
    Jump         = 1'b0;
    Jump_target  = '0;
    Imem_ack     = 1'b1;

    #3;
    checkResetState("reset");

    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    checkOutput("start_req",  32'(Imem_req),  32'd1);
    checkOutput("start_addr", 32'(Imem_addr), 32'h0000);

    // Streaming: one instruction per cycle, addresses 0..3.
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkSlot($sformatf("stream%0d", k), N'(k));
    end

    // Stall on PC=3 for 4 cycles.
    Stall = 1'b1;
    #1;
    checkOutput("stall_req_now", 32'(Imem_req), 32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkSlot($sformatf("stall%0d", k), 16'd3);
      checkOutput($sformatf("stall%0d_req", k), 32'(Imem_req), 32'd0);
    end
    Stall = 1'b0;
    applyStimulus();
    checkSlot("unstall", 16'd4);
    checkOutput("br_fetchpc", 32'(Imem_addr), 32'h0005);

    // Branch while Fetch_PC=5.
    Branch_taken = 1'b1;
    ALU_1_out    = 16'h0014;
    applyStimulus();
    Branch_taken = 1'b0;
    ALU_1_out    = 16'h0000;
    checkOutput("br_valid", 32'(Instr_valid), 32'd0);
    checkOutput("br_req",   32'(Imem_req),    32'd0);
    checkOutput("br_addr",  32'(Imem_addr),   32'h0014);
    applyStimulus();
    checkOutput("br_refetch_req", 32'(Imem_req),    32'd1);
    checkOutput("br_gap_valid",   32'(Instr_valid), 32'd0);
    applyStimulus();
    checkSlot("br_target", 16'h0014);

    // Jump beats branch on the same edge, and both override Stall.
    Stall        = 1'b1;
    Jump         = 1'b1;
    Jump_target  = 16'h0100;
    Branch_taken = 1'b1;
    ALU_1_out    = 16'h0014;
    applyStimulus();
    Jump         = 1'b0;
    Branch_taken = 1'b0;
    Stall        = 1'b0;
    checkOutput("prio_addr",  32'(Imem_addr),   32'h0100);
    checkOutput("prio_valid", 32'(Instr_valid), 32'd0);
    checkOutput("prio_req",   32'(Imem_req),    32'd0);
    applyStimulus();
    applyStimulus();
    checkSlot("prio_target", 16'h0100);

    // Redirect while already in REDIRECT keeps the newer target.
    Jump        = 1'b1;
    Jump_target = 16'h0200;
    applyStimulus();
    Jump_target = 16'hFFFF;
    applyStimulus();
    Jump = 1'b0;
    checkOutput("rr_addr", 32'(Imem_addr), 32'hFFFF);
    checkOutput("rr_req",  32'(Imem_req),  32'd0);
    applyStimulus();
    applyStimulus();
    checkSlot("wrap_top", 16'hFFFF);
    checkOutput("wrap_ppo",  32'(PC_plus_one), 32'h0000);
    checkOutput("wrap_addr", 32'(Imem_addr),   32'h0000);
    applyStimulus();
    checkSlot("wrap_zero", 16'h0000);

    // No ack: the request stays up and the consumed slot empties.
    Imem_ack = 1'b0;
    applyStimulus();
    checkOutput("noack_valid", 32'(Instr_valid), 32'd0);
    checkOutput("noack_req",   32'(Imem_req),    32'd1);
    checkOutput("noack_addr",  32'(Imem_addr),   32'h0001);
    Imem_ack = 1'b1;
    applyStimulus();
    checkSlot("ack_again", 16'h0001);

    // Mid-stream reset clears outputs without waiting for a clock.
    rst = 1'b1;
    #1;
    checkResetState("midreset");
    applyStimulus();
    checkResetState("midreset_edge");
    rst = 1'b0;
    applyStimulus();
    checkOutput("rel_req",  32'(Imem_req),  32'd1);
    checkOutput("rel_addr", 32'(Imem_addr), 32'h0000);
    applyStimulus();
    checkSlot("rel_first", 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter N, default 16: datapath/address width.
REQ-002 Parameter RESET_PC, default 0: fetch address loaded on reset.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 Stall  input  1  decode cannot accept; the held instruction is not consumed.
REQ-006 Branch_taken  input  1  redirect fetch to ALU_1_out.
REQ-007 ALU_1_out  input  N  branch target (PC_plus_one + offset) from the branch-target adder.
REQ-008 Jump  input  1  redirect fetch to Jump_target.
REQ-009 Jump_target  input  N  register-indirect jump target.
REQ-010 Imem_req  output  1  instruction memory read request.
REQ-011 Imem_addr  output  N  instruction memory read address.
REQ-012 Imem_ack  input  1  memory returns Imem_data this cycle.
REQ-013 Imem_data  input  N  instruction word.
REQ-014 Instr  output  N  fetched instruction, registered.
REQ-015 Instr_valid  output  1  Instr, PC and PC_plus_one are meaningful.
REQ-016 PC  output  N  address of Instr.
REQ-017 PC_plus_one  output  N  PC + 1; feeds the branch-target adder.

Function
REQ-018 The block SHALL hold internal register Fetch_PC; Imem_addr SHALL equal Fetch_PC at all times.
REQ-019 FSM states SHALL be IDLE, FETCH and REDIRECT.
REQ-020 IDLE: Imem_req=0; next state FETCH unconditionally.
REQ-021 FETCH: Imem_req = !(Instr_valid && Stall).
REQ-022 REDIRECT: Imem_req=0 for exactly one cycle; next state FETCH.
REQ-023 Transfer SHALL occur on an edge where Imem_req=1, Imem_ack=1 and no redirect is active.
REQ-024 A transfer SHALL load Instr<=Imem_data, PC<=Fetch_PC, PC_plus_one<=Fetch_PC+1, Instr_valid<=1 and Fetch_PC<=Fetch_PC+1.
REQ-025 Imem_req may drop without a transfer; memory holds no outstanding state.
REQ-026 Consumption SHALL occur on an edge where Instr_valid=1 and Stall=0; Instr_valid<=0 unless a transfer occurs on the same edge.
REQ-027 With Imem_ack held 1 and Stall=0, one instruction SHALL be delivered per cycle.
REQ-028 While Instr_valid=1 and Stall=1, Instr/PC/PC_plus_one SHALL hold and no transfer SHALL occur.
REQ-029 A redirect SHALL be Jump or Branch_taken sampled on an edge in any state; Jump SHALL take priority over Branch_taken.
REQ-030 On a redirect edge: Fetch_PC<=target, Instr_valid<=0, state<=REDIRECT, and any same-cycle transfer SHALL be discarded.
REQ-031 A redirect SHALL override Stall.
REQ-032 A redirect while in REDIRECT SHALL load the newer target and remain in REDIRECT.
REQ-033 Arithmetic SHALL be modulo 2^N: 0xFFFF+1 wraps to 0x0000 in both Fetch_PC and PC_plus_one.
REQ-034 Outputs Instr, PC and PC_plus_one SHALL be registered; Imem_req is a function of state, Instr_valid and Stall only.

Reset
REQ-035 While rst=1, regardless of clk: state=IDLE, Fetch_PC=RESET_PC, Instr=0, PC=0, PC_plus_one=0, Instr_valid=0, Imem_req=0.
REQ-036 Reset asserted mid-fetch SHALL abandon the fetch; after release the first request SHALL address RESET_PC.
REQ-037 After rst deasserts, the first edge SHALL move IDLE->FETCH; Imem_req=1 from then on.

Verification
REQ-038 Reset: rst=1 mid-stream -> all outputs 0 immediately; release -> Imem_req=1 after first edge with Imem_addr=0x0000.
REQ-039 Streaming: Imem_ack=1, Stall=0, Imem_data=addr^0xA5A5 -> Instr_valid=1 every cycle; PC 0,1,2,3; PC_plus_one 1,2,3,4; Instr 0xA5A5,0xA5A4,...
REQ-040 Stall: Stall=1 for 4 cycles while PC=3 -> PC=3, Instr held, Imem_req=0; Stall=0 -> next delivered PC=4, no instruction lost or duplicated.
REQ-041 Branch: Branch_taken=1, ALU_1_out=0x0014 while Fetch_PC=5 -> Instr_valid=0 next cycle, one cycle with Imem_req=0; next delivered PC=0x0014, PC_plus_one=0x0015; word from address 5 discarded.
REQ-042 Priority: Jump=1 with Jump_target=0x0100 and Branch_taken=1 with ALU_1_out=0x0014 on the same edge, Stall=1 -> next delivered PC=0x0100.
REQ-043 Wrap: Jump to 0xFFFF -> PC=0xFFFF, PC_plus_one=0x0000; next Imem_addr=0x0000.
